// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor. It adds or subtracts two
// WIDTH-bit operands STEP bits per clock, LSB first, and reports
// unsigned carry/borrow and two's-complement overflow.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - begin an operation (sampled only in IDLE)
//   mode     - 0 = a+b, 1 = a-b (sampled with start)
//   a, b     - operands (sampled with start)
//   busy     - high while the operation is in progress
//   done     - one-cycle pulse, result and flags valid
//   result   - sum/difference modulo 2^WIDTH
//   carry    - unsigned carry-out of add (0 in subtract mode)
//   borrow   - unsigned borrow of subtract (0 in add mode)
//   overflow - signed overflow of the selected operation
//
// state | meaning
// IDLE  | waiting for start; result and flags hold
// BUSY  | processing STEP bits per edge, WIDTH/STEP edges in total
// DONE  | one-cycle done pulse, then back to IDLE
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             cin;
  logic             sub_q;
  logic             sign_a, sign_b;
  logic [STEP:0]    chunk;
  logic             last;

  assign last  = (cnt == CW'(N - 1));
  // b_sh already holds the effective operand (~b when subtracting), and cin
  // starts at 1 for subtraction, so this is a + ~b + 1.
  assign chunk = {1'b0, a_sh[STEP-1:0]} + {1'b0, b_sh[STEP-1:0]}
               + {{STEP{1'b0}}, cin};

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      cin      <= 1'b0;
      sub_q    <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= mode ? ~b : b;
            cnt    <= '0;
            cin    <= mode;
            sub_q  <= mode;
            sign_a <= a[WIDTH-1];
            sign_b <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
          end
        end
        BUSY: begin
          result[cnt*STEP +: STEP] <= chunk[STEP-1:0];
          a_sh <= a_sh >> STEP;
          b_sh <= b_sh >> STEP;
          cin  <= chunk[STEP];
          cnt  <= cnt + CW'(1);
          if (last) begin
            // chunk[STEP-1] is the result sign bit being written this edge.
            carry    <= sub_q ? 1'b0 : chunk[STEP];
            borrow   <= sub_q ? ~chunk[STEP] : 1'b0;
            overflow <= (sign_a == sign_b) && (chunk[STEP-1] != sign_a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>= 2).
REQ-002 Parameter STEP, default 1, bits processed per clock; WIDTH SHALL be an integer multiple of STEP.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress (BUSY state).
REQ-010 done  output  1  single-cycle pulse: result and flags valid.
REQ-011 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 carry  output  1  unsigned carry-out of add; 0 in subtract mode.
REQ-013 borrow  output  1  unsigned borrow-out of subtract (a < b); 0 in add mode.
REQ-014 overflow  output  1  two's-complement signed overflow of the selected operation.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; encoding is free.
REQ-016 IDLE: start=1 at a rising edge latches a, b, mode, clears the step counter and internal carry-in (add: 0, subtract: 1), enters BUSY.
REQ-017 Subtraction SHALL be computed as a + ~b + 1; borrow = inverse of final carry-out.
REQ-018 BUSY: each rising edge processes the next STEP bits LSB-first, writing them into result and updating the internal carry.
REQ-019 BUSY SHALL last exactly N = WIDTH/STEP edges; the N-th edge enters DONE.
REQ-020 Latency: done SHALL be high in the cycle following the N-th edge after the accepting edge (N=8 at defaults; N=1 when STEP=WIDTH).
REQ-021 DONE lasts exactly one cycle (done=1, busy=0), then IDLE unconditionally.
REQ-022 carry, borrow, overflow SHALL be updated only on the edge entering DONE; overflow = (sign of A == sign of effective B operand) and (sign of result != sign of A).
REQ-023 result and flags SHALL hold their values in IDLE until the next operation completes; result bits MAY change during BUSY.
REQ-024 start in BUSY or DONE SHALL be ignored (no queuing); operands changing during BUSY SHALL NOT affect the operation.
REQ-025 busy SHALL be high exactly in BUSY; done and busy SHALL never be high together.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, carry=0, borrow=0, overflow=0, counter and internal carry cleared.
REQ-027 Reset asserted mid-operation SHALL abort it; no done pulse for that operation after release.
REQ-028 First start accepted on the first rising edge with rst_n high and state IDLE.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-029 add 8'hFF + 8'h01 -> result 8'h00, carry 1, overflow 0, done exactly 9 cycles after accepting edge, busy high 8 cycles.
REQ-030 sub 8'h05 - 8'h07 -> result 8'hFE, borrow 1, carry 0, overflow 0.
REQ-031 add 8'h7F + 8'h01 -> 8'h80, overflow 1, carry 0; sub 8'h80 - 8'h01 -> 8'h7F, overflow 1, borrow 0.
REQ-032 start pulsed at BUSY cycle 3 with new operands -> ignored; single done with original result.
REQ-033 rst_n low at BUSY cycle 4 -> all outputs 0 asynchronously, no done after release; next start completes normally.
REQ-034 STEP=8 and STEP=4 builds, random operands both modes -> result/flags match reference arithmetic, latency 1 and 2 BUSY edges respectively.
